// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared types and constants for the PC sequencer
//
// Purpose : FSM state encoding, next-PC select codes and the default reset
//           vector shared by pc_sequencer and pc_next_mux.
// Ports   : none (package).
package pc_sequencer_pkg;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0040_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_J    = 3'd2,
    SEL_JR   = 3'd3,
    SEL_HOLD = 3'd4
  } sel_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control/status bundle between decode and the PC stage
//
// Purpose : groups the redirect controls from decode/execute and the PC
//           stage outputs into one interface.
// Ports   : master modport - drives stall/branch/jump/halt controls, reads PC
//           and status; slave modport - the PC sequencer itself.
interface pc_sequencer_if #(
  parameter int N_BITS = 32
);

  logic              stall_i;
  logic              branch_taken_i;
  logic [N_BITS-1:0] branch_offset_i;
  logic              jump_i;
  logic [25:0]       jump_index_i;
  logic              jump_reg_i;
  logic [N_BITS-1:0] jump_reg_addr_i;
  logic              halt_i;

  logic [N_BITS-1:0] pc_o;
  logic [N_BITS-1:0] pc_plus4_o;
  logic              fetch_valid_o;
  logic              halted_o;
  logic              misaligned_o;

  modport master (
    output stall_i, branch_taken_i, branch_offset_i, jump_i, jump_index_i,
           jump_reg_i, jump_reg_addr_i, halt_i,
    input  pc_o, pc_plus4_o, fetch_valid_o, halted_o, misaligned_o
  );

  modport slave (
    input  stall_i, branch_taken_i, branch_offset_i, jump_i, jump_index_i,
           jump_reg_i, jump_reg_addr_i, halt_i,
    output pc_o, pc_plus4_o, fetch_valid_o, halted_o, misaligned_o
  );

endinterface

// File: rtl/pc_sequencer_pc_next_mux.sv
// rtl/pc_sequencer_pc_next_mux.sv - combinational next-PC priority select
//
// Purpose : picks the next PC by priority (halt/stall hold, JR, J, branch,
//           sequential) and flags a redirect target that is not word aligned.
// Ports   : pc_i, pc_plus4_i        - current PC and PC+4
//           halt_i, stall_i          - hold requests
//           jump_reg_i/_addr_i       - JR/JALR and rs value
//           jump_i, jump_index_i     - J/JAL and instr[25:0]
//           branch_taken_i/_offset_i - taken branch and pre-shifted offset
//           next_pc_o, misaligned_o  - selected PC and misalignment flag
module pc_next_mux
  import pc_sequencer_pkg::*;
#(
  parameter int N_BITS = 32
) (
  input  logic [N_BITS-1:0] pc_i,
  input  logic [N_BITS-1:0] pc_plus4_i,
  input  logic              halt_i,
  input  logic              stall_i,
  input  logic              jump_reg_i,
  input  logic [N_BITS-1:0] jump_reg_addr_i,
  input  logic              jump_i,
  input  logic [25:0]       jump_index_i,
  input  logic              branch_taken_i,
  input  logic [N_BITS-1:0] branch_offset_i,
  output logic [N_BITS-1:0] next_pc_o,
  output logic              misaligned_o
);

  sel_e              sel;
  logic [N_BITS-1:0] jump_target;
  logic [N_BITS-1:0] branch_target;

  // Pseudo-direct J target keeps the top nibble of PC+4; only meaningful for
  // a 32-bit datapath.
  assign jump_target   = {pc_plus4_i[N_BITS-1:N_BITS-4], jump_index_i, 2'b00};
  assign branch_target = pc_plus4_i + branch_offset_i;

  always_comb begin
    sel = SEL_SEQ;
    if (halt_i || stall_i) begin
      sel = SEL_HOLD;
    end else if (jump_reg_i) begin
      sel = SEL_JR;
    end else if (jump_i) begin
      sel = SEL_J;
    end else if (branch_taken_i) begin
      sel = SEL_BR;
    end
  end

  always_comb begin
    next_pc_o    = pc_plus4_i;
    misaligned_o = 1'b0;
    case (sel)
      SEL_HOLD: next_pc_o = pc_i;
      SEL_JR:   next_pc_o = jump_reg_addr_i;
      SEL_J:    next_pc_o = jump_target;
      SEL_BR:   next_pc_o = branch_target;
      default:  next_pc_o = pc_plus4_i;
    endcase
    // Only redirects can land off a word boundary; the sequential path
    // inherits alignment from the reset vector.
    if (sel == SEL_JR || sel == SEL_J || sel == SEL_BR) begin
      misaligned_o = |next_pc_o[1:0];
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - MIPS program-counter stage with boot/run/halt FSM
//
// Purpose : holds the PC, applies the next-PC choice from pc_next_mux while
//           running, and sequences BOOT -> RUN -> HALT.
// Ports   : clk   - rising-edge clock
//           reset - asynchronous active-low reset
//           bus   - pc_sequencer_if.slave: redirect/stall/halt controls in;
//                   pc_o, pc_plus4_o, fetch_valid_o, halted_o,
//                   misaligned_o out
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                N_BITS       = 32,
  parameter logic [N_BITS-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic                 clk,
  input  logic                 reset,
  pc_sequencer_if.slave        bus
);

  state_e            state;
  logic [N_BITS-1:0] pc_q;
  logic [N_BITS-1:0] pc_plus4;
  logic [N_BITS-1:0] next_pc;
  logic              target_misaligned;
  logic              fetch_valid_q;
  logic              halted_q;
  logic              misaligned_q;

  assign pc_plus4 = pc_q + N_BITS'(4);

  pc_next_mux #(
    .N_BITS (N_BITS)
  ) u_next_mux (
    .pc_i            (pc_q),
    .pc_plus4_i      (pc_plus4),
    .halt_i          (bus.halt_i),
    .stall_i         (bus.stall_i),
    .jump_reg_i      (bus.jump_reg_i),
    .jump_reg_addr_i (bus.jump_reg_addr_i),
    .jump_i          (bus.jump_i),
    .jump_index_i    (bus.jump_index_i),
    .branch_taken_i  (bus.branch_taken_i),
    .branch_offset_i (bus.branch_offset_i),
    .next_pc_o       (next_pc),
    .misaligned_o    (target_misaligned)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= BOOT;
      pc_q          <= RESET_VECTOR;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state         <= RUN;
          fetch_valid_q <= 1'b1;
        end
        RUN: begin
          if (bus.halt_i) begin
            state         <= HALT;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b1;
          end else if (target_misaligned) begin
            // Refuse the bad redirect: PC stays put and the core stops.
            state         <= HALT;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b1;
            misaligned_q  <= 1'b1;
          end else begin
            pc_q <= next_pc;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state         <= BOOT;
          fetch_valid_q <= 1'b0;
          halted_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_o          = pc_q;
  assign bus.pc_plus4_o    = pc_plus4;
  assign bus.fetch_valid_o = fetch_valid_q;
  assign bus.halted_o      = halted_q;
  assign bus.misaligned_o  = misaligned_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0040_0000;

  logic clk;
  logic rst_n;

  pc_sequencer_if #(.N_BITS(32)) bus ();

  pc_sequencer #(
    .N_BITS       (32),
    .RESET_VECTOR (RV)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] off;
    logic        j;
    logic [25:0] idx;
    logic        jr;
    logic [31:0] addr;
    logic        halt;
    logic [31:0] exp_pc;
    logic        exp_fv;
    logic        exp_halted;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[15];

  // Reference model state
  logic [31:0] m_pc;
  bit          m_booted;
  bit          m_halted;
  bit          m_mis;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic stall, input logic br, input logic [31:0] off,
                        input logic j, input logic [25:0] idx, input logic jr,
                        input logic [31:0] addr, input logic halt);
    bus.stall_i         = stall;
    bus.branch_taken_i  = br;
    bus.branch_offset_i = off;
    bus.jump_i          = j;
    bus.jump_index_i    = idx;
    bus.jump_reg_i      = jr;
    bus.jump_reg_addr_i = addr;
    bus.halt_i          = halt;
  endtask

  task automatic clear_in();
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [31:0] pc, input logic fv,
                            input logic h, input logic mis);
    check({tag, ".pc"},       bus.pc_o,          pc);
    check({tag, ".pc_plus4"}, bus.pc_plus4_o,    pc + 32'd4);
    check({tag, ".fetch_v"},  {31'b0, bus.fetch_valid_o}, {31'b0, fv});
    check({tag, ".halted"},   {31'b0, bus.halted_o},      {31'b0, h});
    check({tag, ".misalign"}, {31'b0, bus.misaligned_o},  {31'b0, mis});
  endtask

  // Asserts reset mid-cycle, checks outputs before any clock edge, then
  // releases on a falling edge so the next rising edge is the BOOT cycle.
  task automatic pulse_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs({tag, ".async"}, RV, 1'b0, 1'b0, 1'b0);
    clear_in();
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = RV; m_booted = 0; m_halted = 0; m_mis = 0;
  endtask

  // Behavioural model: one clock edge worth of sequencing rules.
  task automatic model_step();
    logic [31:0] seq, tgt;
    bit has_tgt;
    if (!m_booted) begin
      m_booted = 1;
    end else if (!m_halted) begin
      if (bus.halt_i) begin
        m_halted = 1;
      end else if (!bus.stall_i) begin
        seq     = m_pc + 32'd4;
        has_tgt = 1;
        tgt     = seq;
        if (bus.jump_reg_i)          tgt = bus.jump_reg_addr_i;
        else if (bus.jump_i)         tgt = (seq & 32'hF000_0000) | ({6'b0, bus.jump_index_i} * 4);
        else if (bus.branch_taken_i) tgt = seq + bus.branch_offset_i;
        else                         has_tgt = 0;
        if (has_tgt && (tgt % 4) != 0) begin
          m_mis    = 1;
          m_halted = 1;
        end else begin
          m_pc = tgt;
        end
      end
    end
  endtask

  initial begin
    vecs[0]  = '{0, 0, 32'h0,        0, 26'h0,       0, 32'h0,        0, 32'h0040_0000, 1, 0, 0};
    vecs[1]  = '{0, 0, 32'h0,        0, 26'h0,       0, 32'h0,        0, 32'h0040_0004, 1, 0, 0};
    vecs[2]  = '{0, 0, 32'h0,        0, 26'h0,       0, 32'h0,        0, 32'h0040_0008, 1, 0, 0};
    vecs[3]  = '{0, 0, 32'h0,        0, 26'h0,       0, 32'h0,        0, 32'h0040_000C, 1, 0, 0};
    vecs[4]  = '{0, 0, 32'h0,        0, 26'h0,       0, 32'h0,        0, 32'h0040_0010, 1, 0, 0};
    vecs[5]  = '{0, 1, 32'hFFFF_FFF0, 0, 26'h0,      0, 32'h0,        0, 32'h0040_0004, 1, 0, 0};
    vecs[6]  = '{0, 0, 32'h0,        0, 26'h0,       1, 32'h0040_0010, 0, 32'h0040_0010, 1, 0, 0};
    vecs[7]  = '{0, 1, 32'h0000_0020, 0, 26'h0,      0, 32'h0,        0, 32'h0040_0034, 1, 0, 0};
    vecs[8]  = '{0, 0, 32'h0,        0, 26'h0,       1, 32'h0040_0020, 0, 32'h0040_0020, 1, 0, 0};
    vecs[9]  = '{0, 0, 32'h0,        1, 26'h010_0008, 0, 32'h0,       0, 32'h0040_0020, 1, 0, 0};
    vecs[10] = '{0, 0, 32'h0,        1, 26'h010_0008, 1, 32'h0040_0100, 0, 32'h0040_0100, 1, 0, 0};
    vecs[11] = '{1, 1, 32'h0000_0020, 0, 26'h0,      0, 32'h0,        0, 32'h0040_0100, 1, 0, 0};
    vecs[12] = '{1, 1, 32'h0000_0020, 0, 26'h0,      0, 32'h0,        0, 32'h0040_0100, 1, 0, 0};
    vecs[13] = '{1, 0, 32'h0,        0, 26'h0,       0, 32'h0,        1, 32'h0040_0100, 0, 1, 0};
    vecs[14] = '{0, 0, 32'h0,        0, 26'h0,       1, 32'h0040_0200, 0, 32'h0040_0100, 0, 1, 0};

    rst_n = 1'b1;
    clear_in();
    #1;
    rst_n = 1'b0;
    #2;
    check_outs("reset", RV, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outs("boot", RV, 1'b0, 1'b0, 1'b0);

    // Directed table
    for (int i = 0; i < 15; i++) begin
      set_in(vecs[i].stall, vecs[i].br, vecs[i].off, vecs[i].j, vecs[i].idx,
             vecs[i].jr, vecs[i].addr, vecs[i].halt);
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_fv,
                 vecs[i].exp_halted, vecs[i].exp_mis);
    end

    // Misaligned JR target, then reset clears the sticky flag at once
    pulse_reset("rst1");
    step();
    check_outs("mis.boot", RV, 1'b1, 1'b0, 1'b0);
    set_in(0, 0, 32'h0, 0, 26'h0, 1, 32'h0040_0102, 0);
    step();
    check_outs("mis.jr", RV, 1'b0, 1'b1, 1'b1);
    clear_in();
    step();
    check_outs("mis.stay", RV, 1'b0, 1'b1, 1'b1);
    pulse_reset("rst2");

    // Misaligned branch target
    step();
    set_in(0, 1, 32'h0000_0002, 0, 26'h0, 0, 32'h0, 0);
    step();
    check_outs("mis.br", RV, 1'b0, 1'b1, 1'b1);
    pulse_reset("rst3");

    // Wraparound past the top of the address space
    step();
    set_in(0, 0, 32'h0, 0, 26'h0, 1, 32'hFFFF_FFFC, 0);
    step();
    check_outs("wrap.jr", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    check("wrap.p4top", bus.pc_plus4_o, 32'h0000_0000);
    clear_in();
    step();
    check_outs("wrap.seq", 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    check("wrap.p4", bus.pc_plus4_o, 32'h0000_0004);

    // Randomized run against the model
    pulse_reset("rst4");
    for (int i = 0; i < 800; i++) begin
      logic [31:0] r;
      r = $urandom;
      bus.stall_i         = ($urandom_range(0, 5) == 0);
      bus.branch_taken_i  = r[0];
      bus.jump_i          = r[1] & r[2];
      bus.jump_reg_i      = r[3] & r[4];
      bus.halt_i          = ($urandom_range(0, 63) == 0);
      bus.jump_index_i    = 26'($urandom);
      bus.branch_offset_i = {$urandom_range(0, 1) ? 16'hFFFF : 16'h0000, 16'($urandom)} & 32'hFFFF_FFFC;
      bus.jump_reg_addr_i = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 31) == 0) bus.jump_reg_addr_i[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 31) == 0) bus.branch_offset_i[1:0] = 2'($urandom_range(1, 3));
      model_step();
      step();
      check_outs($sformatf("rnd%0d", i), m_pc, m_booted && !m_halted, m_halted, m_mis);
      if (m_halted && $urandom_range(0, 3) == 0) begin
        pulse_reset($sformatf("rnd_rst%0d", i));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage of the single-cycle MIPS datapath, directly downstream of the branch-offset shift-left-2 stage; consumes its already-shifted offset.
- Holds the PC register and computes PC+4, the branch target (PC+4 + shifted offset), the J/JAL target and the JR target.
- Selects the next PC and sequences boot, run and halt with a small FSM.
- Drives the instruction-memory address and the PC+4 value used for JAL link.

Parameters:
- N_BITS, 32, datapath/PC width; jump-target logic requires N_BITS = 32.
- RESET_VECTOR, 32'h0040_0000, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- stall_i  input  1  hold PC this cycle.
- branch_taken_i  input  1  branch instruction AND condition true.
- branch_offset_i  input  N_BITS  sign-extended immediate already shifted left by 2.
- jump_i  input  1  J/JAL.
- jump_index_i  input  26  instr[25:0].
- jump_reg_i  input  1  JR/JALR.
- jump_reg_addr_i  input  N_BITS  rs register value.
- halt_i  input  1  exit syscall decoded.
- pc_o  output  N_BITS  current PC / instruction address.
- pc_plus4_o  output  N_BITS  pc_o + 4 (combinational from pc_o).
- fetch_valid_o  output  1  instruction at pc_o is to be executed.
- halted_o  output  1  FSM in HALT.
- misaligned_o  output  1  sticky: a redirect target had bits [1:0] != 0.

Behaviour:
- Reset (async, active-low, reset = 0):
  - pc_o = RESET_VECTOR, state = BOOT, fetch_valid_o = 0, halted_o = 0, misaligned_o = 0.
  - Reset asserted mid-operation overrides everything immediately, without waiting for a clock edge.
- FSM, registered:
  - BOOT: one cycle; PC held at RESET_VECTOR; fetch_valid_o = 0; always moves to RUN.
  - RUN: fetch_valid_o = 1; PC updates on each rising edge per the rules below.
  - HALT: PC frozen; fetch_valid_o = 0; halted_o = 1; left only by reset.
- Next-PC priority in RUN (highest first):
  1. halt_i: PC held, go to HALT. Wins over stall and redirects.
  2. stall_i: PC held, state stays RUN; redirect inputs are ignored this cycle.
  3. jump_reg_i: target = jump_reg_addr_i.
  4. jump_i: target = {pc_plus4[31:28], jump_index_i, 2'b00}.
  5. branch_taken_i: target = pc_plus4 + branch_offset_i.
  6. Otherwise: pc_plus4.
- Arithmetic: all additions are modulo 2^N_BITS with no overflow detection. 0xFFFF_FFFC + 4 = 0x0000_0000.
- Misaligned target: applies to priorities 3–5 only.
  - If the selected target[1:0] != 0: PC is not updated, misaligned_o is set and stays set until reset, and the FSM goes to HALT on the same edge.
  - The sequential path (6) cannot be misaligned once RESET_VECTOR is aligned.
- Latency: a redirect asserted in cycle n appears on pc_o in cycle n+1; there are no delay slots.
- pc_plus4_o is always pc_o + 4, including in BOOT and HALT.
- Inputs are ignored in BOOT and HALT.

Decomposition:
- Shared package holds:
  - State encoding constants: BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2.
  - Next-PC select constants: SEL_SEQ, SEL_BR, SEL_J, SEL_JR, SEL_HOLD.
  - Default RESET_VECTOR.
- One sub-module, pc_next_mux: purely combinational priority select plus target computation, outputting next_pc and a misaligned flag.
- pc_sequencer keeps the PC register, the FSM and the sticky flags.

Test Plan:
- Reset, release, 4 clocks with no controls -> pc_o sequence 0x00400000 (BOOT, fetch_valid_o = 0), 0x00400000 (RUN), 0x00400004, 0x00400008.
- At pc_o = 0x00400010, branch_taken_i = 1, branch_offset_i = 0xFFFFFFF0 -> next pc_o = 0x00400004. With offset 0x00000020 -> 0x00400034.
- At pc_o = 0x00400020, jump_i = 1, jump_index_i = 0x0100008 -> pc_o = 0x00400020. In the same cycle also set jump_reg_i = 1 with addr 0x00400100 -> pc_o = 0x00400100 (JR wins).
- stall_i = 1 together with branch_taken_i = 1 for 2 cycles -> pc_o unchanged both cycles. halt_i = 1 together with stall_i = 1 -> HALT next cycle, halted_o = 1, pc_o frozen, fetch_valid_o = 0.
- jump_reg_addr_i = 0x00400102 with jump_reg_i = 1 -> misaligned_o = 1, halted_o = 1, pc_o unchanged. Pulse reset low -> all outputs return to reset values immediately.
- Force pc_o to 0xFFFFFFFC via jump_reg_i, then one clock with no controls -> pc_o = 0x00000000 and pc_plus4_o = 0x00000004.
